// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-port register file with pending-write scoreboard
// Optional same-cycle write-to-read bypass: define RF_BYPASS_EN.
module register_file_mp #(
  parameter  int DATA_W = 32,
  parameter  int NREGS  = 32,
  parameter  int NRD    = 2,
  parameter  int NWR    = 2,
  localparam int ADDR_W = $clog2(NREGS),
  localparam int CNT_W  = $clog2(NREGS + 1)
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NWR-1:0]        wen,
  input  logic [NWR*ADDR_W-1:0] wsel,
  input  logic [NWR*DATA_W-1:0] wdat,
  input  logic [NRD*ADDR_W-1:0] rsel,
  output logic [NRD*DATA_W-1:0] rdat,
  output logic [NRD-1:0]        rpend,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_sel,
  input  logic                  flush,
  output logic [CNT_W-1:0]      pend_cnt
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  inc, dec;
  logic [ADDR_W-1:0] waddr, raddr;

  // Later ports overwrite earlier ones, so the highest-index port wins collisions.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    waddr  = '0;
    for (int i = 0; i < NWR; i++) begin
      waddr = wsel[i*ADDR_W +: ADDR_W];
      if (wen[i] && waddr != '0) begin
        regs_d[waddr] = wdat[i*DATA_W +: DATA_W];
        pend_d[waddr] = 1'b0;
      end
    end
    if (iss_en && iss_sel != '0) pend_d[iss_sel] = 1'b1;
    if (flush) pend_d = '0;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 0; r < NREGS; r++) begin
      inc = inc + CNT_W'(pend_d[r] & ~pend_q[r]);
      dec = dec + CNT_W'(pend_q[r] & ~pend_d[r]);
    end
    cnt_d = flush ? '0 : cnt_q + inc - dec;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      regs_q <= '{default: '0};
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    rdat  = '0;
    rpend = '0;
    raddr = '0;
    for (int j = 0; j < NRD; j++) begin
      raddr = rsel[j*ADDR_W +: ADDR_W];
      rdat[j*DATA_W +: DATA_W] = regs_q[raddr];
      rpend[j] = pend_q[raddr];
`ifdef RF_BYPASS_EN
      // Bypass is suppressed in reset so outputs stay at reset values.
      for (int i = 0; i < NWR; i++) begin
        if (nRST && wen[i] && raddr != '0 && wsel[i*ADDR_W +: ADDR_W] == raddr) begin
          rdat[j*DATA_W +: DATA_W] = wdat[i*DATA_W +: DATA_W];
          rpend[j] = iss_en && (iss_sel == raddr);
        end
      end
`endif
    end
  end

  assign pend_cnt = cnt_q;

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - randomized self-checking bench for register_file_mp
// Expectations follow RF_BYPASS_EN when it is defined for the build.
module tb_register_file_mp;
  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int CW  = 6;

  logic              CLK = 1'b0;
  logic              nRST;
  logic [NWR-1:0]    wen;
  logic [NWR*AW-1:0] wsel;
  logic [NWR*DW-1:0] wdat;
  logic [NRD*AW-1:0] rsel;
  logic [NRD*DW-1:0] rdat;
  logic [NRD-1:0]    rpend;
  logic              iss_en;
  logic [AW-1:0]     iss_sel;
  logic              flush;
  logic [CW-1:0]     pend_cnt;

  int checks = 0;
  int errors = 0;

  register_file_mp #(.DATA_W(DW), .NREGS(NR), .NRD(NRD), .NWR(NWR)) dut (
    .CLK(CLK), .nRST(nRST), .wen(wen), .wsel(wsel), .wdat(wdat),
    .rsel(rsel), .rdat(rdat), .rpend(rpend), .iss_en(iss_en),
    .iss_sel(iss_sel), .flush(flush), .pend_cnt(pend_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: plain arrays of register values and pending flags.
  logic [DW-1:0] m_regs [NR];
  bit            m_pend [NR];
  bit            m_valid = 1'b0;

  always @(posedge CLK) begin
    if (!nRST) begin
      for (int r = 0; r < NR; r++) begin
        m_regs[r] = '0;
        m_pend[r] = 1'b0;
      end
      m_valid = 1'b1;
    end else if (m_valid) begin
      for (int i = 0; i < NWR; i++)
        if (wen[i] && wsel[i*AW +: AW] != 0) begin
          m_regs[wsel[i*AW +: AW]] = wdat[i*DW +: DW];
          m_pend[wsel[i*AW +: AW]] = 1'b0;
        end
      if (iss_en && iss_sel != 0) m_pend[iss_sel] = 1'b1;
      if (flush)
        for (int r = 0; r < NR; r++) m_pend[r] = 1'b0;
    end
  end

  always @(negedge CLK) begin : cmp
    logic [AW-1:0] a;
    logic [DW-1:0] ed;
    logic          ep;
    int            pc;
    if (m_valid) begin
      for (int j = 0; j < NRD; j++) begin
        a  = rsel[j*AW +: AW];
        ed = m_regs[a];
        ep = m_pend[a];
`ifdef RF_BYPASS_EN
        for (int i = 0; i < NWR; i++)
          if (nRST && wen[i] && a != 0 && wsel[i*AW +: AW] == a) begin
            ed = wdat[i*DW +: DW];
            ep = iss_en && (iss_sel == a);
          end
`endif
        chk($sformatf("rdat[%0d] r%0d", j, a), rdat[j*DW +: DW], ed);
        chk($sformatf("rpend[%0d] r%0d", j, a), {31'b0, rpend[j]}, {31'b0, ep});
      end
      pc = 0;
      for (int r = 0; r < NR; r++) pc += int'(m_pend[r]);
      chk("pend_cnt", {26'b0, pend_cnt}, pc);
    end
  end

  task automatic sync();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    wen = '0; iss_en = 1'b0; flush = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rsel = {a1, a0};
    @(negedge CLK);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NR - 1));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; wen = '0; wsel = '0; wdat = '0; rsel = '0;
    iss_en = 1'b0; iss_sel = '0; flush = 1'b0;
    sync(); sync();
    nRST = 1'b1;

    for (int r = 0; r < NR; r++) begin
      rd(AW'(r), AW'(r));
      chk("reset rdat0", rdat[31:0], 32'h0);
      chk("reset rdat1", rdat[63:32], 32'h0);
      chk("reset rpend", {30'b0, rpend}, 32'h0);
      chk("reset cnt", {26'b0, pend_cnt}, 32'h0);
      sync();
    end

    wen = 2'b01; wsel = {5'd0, 5'd0}; wdat = {32'h0, 32'hDEADBEEF};
    sync(); clr();
    rd(0, 0);
    chk("r0 stays zero", rdat[31:0], 32'h0);
    sync();

    wen = 2'b11; wsel = {5'd5, 5'd5}; wdat = {32'h22222222, 32'h11111111};
    sync(); clr();
    rd(5, 5);
    chk("collision port1 wins", rdat[31:0], 32'h22222222);
    sync();

    iss_en = 1'b1; iss_sel = 5'd3;
    sync();
    iss_sel = 5'd7;
    @(negedge CLK); chk("cnt after r3", {26'b0, pend_cnt}, 1);
    sync();
    iss_sel = 5'd9;
    @(negedge CLK); chk("cnt after r7", {26'b0, pend_cnt}, 2);
    sync(); clr();
    @(negedge CLK); chk("cnt after r9", {26'b0, pend_cnt}, 3);
    sync();

    wen = 2'b01; wsel = {5'd0, 5'd7}; wdat = {32'h0, 32'h77};
    sync(); clr();
    rd(7, 7);
    chk("cnt after write r7", {26'b0, pend_cnt}, 2);
    chk("rpend r7 cleared", {31'b0, rpend[0]}, 0);
    sync();

    iss_en = 1'b1; iss_sel = 5'd3; wen = 2'b10; wsel = {5'd3, 5'd0}; wdat = {32'h33, 32'h0};
    sync(); clr();
    rd(3, 3);
    chk("issue beats write", {31'b0, rpend[0]}, 1);
    chk("cnt unchanged", {26'b0, pend_cnt}, 2);
    sync();

    iss_en = 1'b1; iss_sel = 5'd4;
    sync();
    iss_sel = 5'd6;
    sync(); clr();
    @(negedge CLK); chk("cnt four pending", {26'b0, pend_cnt}, 4);
    sync();
    flush = 1'b1; iss_en = 1'b1; iss_sel = 5'd12;
    wen = 2'b01; wsel = {5'd0, 5'd4}; wdat = {32'h0, 32'hA5A5A5A5};
    sync(); clr();
    rd(12, 4);
    chk("flush cnt", {26'b0, pend_cnt}, 0);
    chk("flush beats issue", {31'b0, rpend[0]}, 0);
    chk("flush keeps data", rdat[63:32], 32'hA5A5A5A5);
    sync();

    wen = 2'b01; wsel = {5'd0, 5'd10}; wdat = {32'h0, 32'h12345678};
    rd(10, 10);
`ifdef RF_BYPASS_EN
    chk("bypass same cycle", rdat[31:0], 32'h12345678);
`else
    chk("no bypass same cycle", rdat[31:0], 32'h0);
`endif
    sync(); clr();
    @(negedge CLK);
    chk("write visible next", rdat[31:0], 32'h12345678);
    sync();

    nRST = 1'b0; wen = 2'b01; wsel = {5'd0, 5'd11}; wdat = {32'h0, 32'h55};
    iss_en = 1'b1; iss_sel = 5'd11;
    sync(); clr();
    rd(5, 11);
    chk("reset clears r5", rdat[31:0], 32'h0);
    chk("reset blocks write", rdat[63:32], 32'h0);
    chk("reset blocks issue", {31'b0, rpend[1]}, 0);
    chk("reset cnt", {26'b0, pend_cnt}, 0);
    sync();
    nRST = 1'b1; iss_en = 1'b1; iss_sel = 5'd2;
    sync(); clr();
    @(negedge CLK); chk("post reset issue", {26'b0, pend_cnt}, 1);
    sync();

    for (int n = 0; n < 3000; n++) begin
      nRST    = ($urandom_range(0, 199) != 0);
      wen     = NWR'($urandom_range(0, 3));
      wsel    = {rnd_addr(), rnd_addr()};
      wdat    = {$urandom, $urandom};
      rsel    = {rnd_addr(), rnd_addr()};
      iss_en  = ($urandom_range(0, 1) != 0);
      iss_sel = rnd_addr();
      flush   = ($urandom_range(0, 39) == 0);
      sync();
    end
    nRST = 1'b1; clr();
    sync();
    @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file with an integrated pending-write scoreboard, the next-generation register file for the pipelined and superscalar datapaths. It provides NRD combinational read ports and NWR synchronous write ports. It hardwires register 0 to zero. Per-register pending bits let issue logic detect RAW hazards. It sits between decode/issue (reads and issue marks) and writeback (writes and pending clears).

## Interface
Parameters:
- DATA_W, 32, width of each register
- NREGS, 32, number of registers (power of two, ≥ 2); ADDR_W = $clog2(NREGS)
- NRD, 2, number of read ports
- NWR, 2, number of write ports

Ports:
- CLK  in  1  clock; all state updates on rising edge
- nRST  in  1  reset, synchronous, active-low
- wen  in  NWR  per-port write enable
- wsel  in  NWR*ADDR_W  per-port write address, port i at [i*ADDR_W +: ADDR_W]
- wdat  in  NWR*DATA_W  per-port write data
- rsel  in  NRD*ADDR_W  per-port read address
- rdat  out  NRD*DATA_W  per-port read data
- rpend  out  NRD  pending flag of the addressed register
- iss_en  in  1  mark register iss_sel pending (new in-flight producer)
- iss_sel  in  ADDR_W  register to mark
- flush  in  1  clear all pending bits
- pend_cnt  out  $clog2(NREGS+1)  number of registers currently pending

## Operation
- Register 0 reads 0 on every port and is never pending. Writes to it and issues to it are ignored.
- Writes:
  - Each enabled port writes wdat to wsel at the edge.
  - On an address collision between write ports, the highest-index port wins.
- Pending bits:
  - An enabled write to register r clears pend[r].
  - iss_en sets pend[iss_sel].
  - If an issue and a write target the same register in one cycle, the issue wins and pend stays 1, because the new producer supersedes the old one.
  - flush clears every pend bit. It overrides issue and write clears in the same cycle. Data writes in that cycle still commit.
- pend_cnt is a registered counter. It always equals the popcount of the pend bits. It is updated at each edge by +1/−1/0 per changed bit, or forced to 0 on flush.
- Read ports are combinational from stored state, except when the bypass described under Configuration is enabled.
- Reset (nRST=0 at an edge): all registers 0, all pend 0, pend_cnt 0. Reset overrides any write, issue or flush in the same cycle.

## Timing
- Write latency: data is visible on rdat in the cycle after the write edge (or the same cycle with bypass).
- An issue at edge N makes rpend = 1 from cycle N+1.
- A write at edge N makes rpend = 0 from cycle N+1, unless an issue to the same register occurs at edge N.
- pend_cnt reflects the edge-N update in cycle N+1.
- Outputs during and after reset: rdat = 0, rpend = 0, pend_cnt = 0 (rdat may change combinationally with rsel only after data has been written).
- No back-pressure. Every port accepts every cycle.

## Configuration
- RF_BYPASS_EN defined:
  - When a read port's rsel matches an enabled write port's wsel (nonzero) in the same cycle, rdat returns that wdat, using the highest-index matching port.
  - rpend returns 0 for that read unless iss_en targets the same register in that cycle.
- RF_BYPASS_EN undefined:
  - Reads return stored register contents and stored pend bits only.
  - A same-cycle write is not visible until the next cycle.

## Test plan
- Reset then read all registers on all ports -> rdat = 0, rpend = 0, pend_cnt = 0; write r0 = 0xDEADBEEF -> r0 still reads 0.
- Port 0 writes r5 = 0x11111111 and port 1 writes r5 = 0x22222222 in the same cycle -> r5 reads 0x22222222 next cycle.
- Issue r3, r7, r9 in consecutive cycles -> pend_cnt 1, 2, 3; write r7 -> pend_cnt 2 and rpend(r7) = 0; issue r3 with a simultaneous write to r3 -> rpend(r3) = 1 and pend_cnt unchanged.
- With 4 registers pending, assert flush together with iss_en to r12 and a write r4 = 0xA5A5A5A5 -> pend_cnt = 0, rpend(r12) = 0, r4 reads 0xA5A5A5A5.
- Bypass: write r10 = 0x12345678 while reading r10 in the same cycle -> with RF_BYPASS_EN, rdat = 0x12345678 that cycle; without it, rdat holds the old value and updates the next cycle.
- Drive a write and an issue with nRST low in the same cycle -> no state change beyond reset values. Deassert nRST -> normal operation on the next edge.
